// File: rtl/riscv_run_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_run_ctrl_if                                                    |
// | Host command, core-side and memory-side signals of the run control.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface riscv_run_ctrl_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic [31:0] pc;
    logic [31:0] pc_new;
    logic [31:0] instr;
    logic        cpu_register_we3;
    logic        cpu_data_memory_we;
    logic        register_we3;
    logic        data_memory_we;
    logic        bp_valid;
    logic [31:0] bp_addr;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] retired;

    modport master (
        output cmd_valid, cmd_op, pc_new, instr, cpu_register_we3,
               cpu_data_memory_we, bp_valid, bp_addr,
        input  cmd_ready, pc, register_we3, data_memory_we, halted,
               halt_cause, retired
    );

    modport slave (
        input  cmd_valid, cmd_op, pc_new, instr, cpu_register_we3,
               cpu_data_memory_we, bp_valid, bp_addr,
        output cmd_ready, pc, register_we3, data_memory_we, halted,
               halt_cause, retired
    );
endinterface
`default_nettype wire

// File: rtl/riscv_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_run_ctrl                                                       |
// | PC owner and halt/run/step sequencer for the single-cycle core.      |
// | Optional breakpoint unit: define RUN_CTRL_BREAKPOINT_EN.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module riscv_run_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    riscv_run_ctrl_if.slave     bus
);

    localparam logic [31:0] C_EBREAK  = 32'h0010_0073;
    localparam logic [1:0]  C_OP_RUN  = 2'b01;
    localparam logic [1:0]  C_OP_HALT = 2'b10;
    localparam logic [1:0]  C_OP_STEP = 2'b11;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        halted_q;
    logic [1:0]  halt_cause_q;

    logic        w_active;
    logic        w_ebreak;
    logic        w_bp_hit;
    logic        w_cmd_ready;
    logic        w_cmd_fire;
    logic        w_halt_cmd;
    logic        w_halt_event;
    logic        w_commit;
    logic        w_leave_halt;
    logic [1:0]  w_cause;

    assign w_active     = (state_q == S_RUN) || (state_q == S_STEP);
    assign w_ebreak     = (bus.instr == C_EBREAK);
    assign w_cmd_ready  = (state_q == S_HALT) || (state_q == S_RUN);
    assign w_cmd_fire   = bus.cmd_valid && w_cmd_ready;
    assign w_halt_cmd   = w_cmd_fire && (state_q == S_RUN) && (bus.cmd_op == C_OP_HALT);
    assign w_leave_halt = w_cmd_fire && (state_q == S_HALT)
                          && ((bus.cmd_op == C_OP_RUN) || (bus.cmd_op == C_OP_STEP));
    assign w_halt_event = w_active && (w_ebreak || w_bp_hit || w_halt_cmd);
    assign w_commit     = w_active && !w_halt_event && !reset;
    assign w_cause      = w_ebreak ? 2'd2 : (w_bp_hit ? 2'd3 : 2'd1);

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic skip_bp_q;

    // Leaving HALT arms a one-shot bypass so a resume on the breakpoint PC makes progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_bp_q <= 1'b0;
        end else if (w_leave_halt) begin
            skip_bp_q <= 1'b1;
        end else if (w_commit) begin
            skip_bp_q <= 1'b0;
        end
    end

    assign w_bp_hit = bus.bp_valid && (pc_q == bus.bp_addr) && !skip_bp_q;
`else
    logic w_unused_bp;
    assign w_unused_bp = bus.bp_valid ^ (^bus.bp_addr);
    assign w_bp_hit    = 1'b0;
`endif

    assign pc_d      = w_commit ? bus.pc_new : pc_q;
    assign retired_d = retired_q + {31'd0, w_commit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HALT;
            pc_q         <= RESET_PC;
            retired_q    <= 32'd0;
            halted_q     <= 1'b1;
            halt_cause_q <= 2'd0;
        end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            case (state_q)
                S_HALT: begin
                    if (w_cmd_fire && (bus.cmd_op == C_OP_RUN)) begin
                        state_q  <= S_RUN;
                        halted_q <= 1'b0;
                    end else if (w_cmd_fire && (bus.cmd_op == C_OP_STEP)) begin
                        state_q  <= S_STEP;
                        halted_q <= 1'b0;
                    end
                end
                S_RUN, S_STEP: begin
                    if (w_halt_event) begin
                        state_q      <= S_HALT;
                        halted_q     <= 1'b1;
                        halt_cause_q <= w_cause;
                    end else if (state_q == S_STEP) begin
                        state_q      <= S_HALT;
                        halted_q     <= 1'b1;
                        halt_cause_q <= 2'd1;
                    end
                end
                default: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.pc             = pc_q;
    assign bus.retired        = retired_q;
    assign bus.halted         = halted_q;
    assign bus.halt_cause     = halt_cause_q;
    assign bus.register_we3   = w_commit && bus.cpu_register_we3;
    assign bus.data_memory_we = w_commit && bus.cpu_data_memory_we;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscv_run_ctrl                                                    |
// | Directed bench with a tiny addi/sw core model around the controller. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_riscv_run_ctrl;

    localparam logic [31:0] ADDI_X1_X0_5 = 32'h0050_0093;
    localparam logic [31:0] ADDI_X1_X1_1 = 32'h0010_8093;
    localparam logic [31:0] EBREAK       = 32'h0010_0073;
    localparam logic [31:0] SW_X1_0_X0   = 32'h0010_2023;
    localparam logic [1:0]  OP_NOP  = 2'b00;
    localparam logic [1:0]  OP_RUN  = 2'b01;
    localparam logic [1:0]  OP_HALT = 2'b10;
    localparam logic [1:0]  OP_STEP = 2'b11;

    logic        clk;
    logic        reset;
    logic [31:0] imem [0:15];
    logic [31:0] x1;
    logic [31:0] st_cnt;
    int          n_tests;
    int          n_fail;

    riscv_run_ctrl_if bus ();

    riscv_run_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: fetch, sequential next PC, and decode of addi/sw enables.
    always_comb begin
        bus.instr              = imem[bus.pc[5:2]];
        bus.pc_new             = bus.pc + 32'd4;
        bus.cpu_register_we3   = (bus.instr[6:0] == 7'b0010011);
        bus.cpu_data_memory_we = (bus.instr[6:0] == 7'b0100011);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x1     <= 32'd0;
            st_cnt <= 32'd0;
        end else begin
            if (bus.register_we3 && bus.instr[11:7] == 5'd1)
                x1 <= ((bus.instr[19:15] == 5'd1) ? x1 : 32'd0)
                      + {{20{bus.instr[31]}}, bus.instr[31:20]};
            if (bus.data_memory_we)
                st_cnt <= st_cnt + 32'd1;
        end
    end

    task automatic load_prog(input int kind);
        for (int i = 0; i < 16; i++) imem[i] = (kind == 1) ? SW_X1_0_X0 : 32'h0000_0013;
        if (kind == 0) begin
            imem[0] = ADDI_X1_X0_5;
            imem[1] = ADDI_X1_X1_1;
            imem[2] = EBREAK;
        end else if (kind == 2) begin
            imem[0] = ADDI_X1_X0_5;
            imem[1] = ADDI_X1_X1_1;
            imem[2] = ADDI_X1_X1_1;
            imem[3] = EBREAK;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
    endtask

    task automatic wait_halted(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        load_prog(0);
        do_reset();
        n_tests++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %b want 1", bus.halted); end
        n_tests++; if (bus.halt_cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %0d want 0", bus.halt_cause); end
        n_tests++; if (bus.retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        n_tests++; if (bus.register_we3 !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", bus.register_we3); end
        @(negedge clk);
        n_tests++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL halt_holds_pc: got %h want %h", bus.pc, 32'h0); end
        ok = 1'b1;
    endtask

    task automatic test_run_ebreak();
        bit ok;
        send_cmd(OP_RUN);
        wait_halted(20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL run_timeout: got halted=%b want 1", bus.halted); end
        n_tests++; if (bus.retired !== 32'd2) begin n_fail++; $display("FAIL run_retired: got %0d want 2", bus.retired); end
        n_tests++; if (x1 !== 32'd6) begin n_fail++; $display("FAIL run_x1: got %0d want 6", x1); end
        n_tests++; if (bus.halt_cause !== 2'd2) begin n_fail++; $display("FAIL run_cause: got %0d want 2", bus.halt_cause); end
        n_tests++; if (bus.pc !== 32'h8) begin n_fail++; $display("FAIL run_pc: got %h want %h", bus.pc, 32'h8); end
        // Resuming on the ebreak halts again without committing.
        send_cmd(OP_RUN);
        n_tests++; if (bus.register_we3 !== 1'b0) begin n_fail++; $display("FAIL rerun_we: got %b want 0", bus.register_we3); end
        wait_halted(5, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rerun_timeout: got halted=%b want 1", bus.halted); end
        n_tests++; if (bus.retired !== 32'd2 || bus.pc !== 32'h8) begin n_fail++; $display("FAIL rerun_state: got retired=%0d pc=%h want 2 / 8", bus.retired, bus.pc); end
    endtask

    task automatic test_ebreak_vs_halt();
        load_prog(0);
        do_reset();
        send_cmd(OP_RUN);
        @(posedge clk);
        @(posedge clk);
        send_cmd(OP_HALT);
        n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL ebk_halt_halted: got %b want 1", bus.halted); end
        n_tests++; if (bus.halt_cause !== 2'd2) begin n_fail++; $display("FAIL ebk_halt_cause: got %0d want 2", bus.halt_cause); end
        n_tests++; if (bus.pc !== 32'h8 || bus.retired !== 32'd2) begin n_fail++; $display("FAIL ebk_halt_state: got pc=%h retired=%0d want 8 / 2", bus.pc, bus.retired); end
    endtask

    task automatic test_step();
        load_prog(0);
        do_reset();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_STEP;
        #1;
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL step_ready_before: got %b want 1", bus.cmd_ready); end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL step_ready_low: got %b want 0", bus.cmd_ready); end
        n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL step_halted_low: got %b want 0", bus.halted); end
        n_tests++; if (bus.register_we3 !== 1'b1) begin n_fail++; $display("FAIL step_commit_we: got %b want 1", bus.register_we3); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.halted !== 1'b1 || bus.halt_cause !== 2'd1) begin n_fail++; $display("FAIL step_halt: got halted=%b cause=%0d want 1 / 1", bus.halted, bus.halt_cause); end
        n_tests++; if (bus.pc !== 32'h4 || bus.retired !== 32'd1) begin n_fail++; $display("FAIL step_commit: got pc=%h retired=%0d want 4 / 1", bus.pc, bus.retired); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL step_ready_after: got %b want 1", bus.cmd_ready); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.pc !== 32'h4 || bus.retired !== 32'd1 || x1 !== 32'd5) begin n_fail++; $display("FAIL step_once: got pc=%h retired=%0d x1=%0d want 4 / 1 / 5", bus.pc, bus.retired, x1); end
    endtask

    task automatic test_breakpoint();
        bit ok;
        load_prog(2);
        do_reset();
        bus.bp_valid = 1'b1;
        bus.bp_addr  = 32'h8;
        send_cmd(OP_RUN);
        wait_halted(20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got halted=%b want 1", bus.halted); end
`ifdef RUN_CTRL_BREAKPOINT_EN
        n_tests++; if (bus.halt_cause !== 2'd3 || bus.pc !== 32'h8) begin n_fail++; $display("FAIL bp_hit: got cause=%0d pc=%h want 3 / 8", bus.halt_cause, bus.pc); end
        n_tests++; if (bus.retired !== 32'd2 || x1 !== 32'd6) begin n_fail++; $display("FAIL bp_nowrite: got retired=%0d x1=%0d want 2 / 6", bus.retired, x1); end
        send_cmd(OP_RUN);
        wait_halted(20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_resume_timeout: got halted=%b want 1", bus.halted); end
`endif
        n_tests++; if (bus.halt_cause !== 2'd2 || bus.pc !== 32'hC) begin n_fail++; $display("FAIL bp_pass: got cause=%0d pc=%h want 2 / c", bus.halt_cause, bus.pc); end
        n_tests++; if (bus.retired !== 32'd3 || x1 !== 32'd7) begin n_fail++; $display("FAIL bp_pass_commit: got retired=%0d x1=%0d want 3 / 7", bus.retired, x1); end
        bus.bp_valid = 1'b0;
    endtask

    task automatic test_halt_store();
        load_prog(1);
        do_reset();
        send_cmd(OP_RUN);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.data_memory_we !== 1'b1) begin n_fail++; $display("FAIL store_we_run: got %b want 1", bus.data_memory_we); end
        n_tests++; if (bus.retired !== 32'd4) begin n_fail++; $display("FAIL store_retired_run: got %0d want 4", bus.retired); end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_HALT;
        #1;
        n_tests++; if (bus.data_memory_we !== 1'b0) begin n_fail++; $display("FAIL store_we_halt_cycle: got %b want 0", bus.data_memory_we); end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        n_tests++; if (bus.halted !== 1'b1 || bus.halt_cause !== 2'd1) begin n_fail++; $display("FAIL store_halt: got halted=%b cause=%0d want 1 / 1", bus.halted, bus.halt_cause); end
        repeat (2) @(negedge clk);
        n_tests++; if (bus.data_memory_we !== 1'b0) begin n_fail++; $display("FAIL store_we_after: got %b want 0", bus.data_memory_we); end
        n_tests++; if (bus.retired !== 32'd4 || st_cnt !== 32'd4 || bus.pc !== 32'h10) begin n_fail++; $display("FAIL store_frozen: got retired=%0d stores=%0d pc=%h want 4 / 4 / 10", bus.retired, st_cnt, bus.pc); end
    endtask

    task automatic test_reset_mid_run();
        load_prog(1);
        do_reset();
        send_cmd(OP_RUN);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++; if (bus.data_memory_we !== 1'b0 || bus.register_we3 !== 1'b0) begin n_fail++; $display("FAIL rst_run_we: got dm=%b rf=%b want 0 / 0", bus.data_memory_we, bus.register_we3); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++; if (bus.pc !== 32'h0 || bus.retired !== 32'd0) begin n_fail++; $display("FAIL rst_run_regs: got pc=%h retired=%0d want 0 / 0", bus.pc, bus.retired); end
        n_tests++; if (bus.halted !== 1'b1 || bus.halt_cause !== 2'd0) begin n_fail++; $display("FAIL rst_run_halt: got halted=%b cause=%0d want 1 / 0", bus.halted, bus.halt_cause); end
    endtask

    task automatic test_wrap();
        load_prog(0);
        do_reset();
        @(negedge clk);
        force dut.retired_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_q;
        #1;
        n_tests++; if (bus.retired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", bus.retired); end
        send_cmd(OP_STEP);
        @(posedge clk);
        #1;
        n_tests++; if (bus.retired !== 32'd0 || bus.pc !== 32'h4) begin n_fail++; $display("FAIL wrap: got retired=%h pc=%h want 0 / 4", bus.retired, bus.pc); end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.bp_valid  = 1'b0;
        bus.bp_addr   = 32'h0;
        test_reset();
        test_run_ebreak();
        test_ebreak_vs_halt();
        test_step();
        test_breakpoint();
        test_halt_store();
        test_reset_mid_run();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Run controller for the single-cycle `riscv_cpu` core. It owns the architectural PC register and sequences the core through halt, run and single-step operation. It gates the core's register-file and data-memory write enables so that no instruction commits while the core is halted, and it counts retired instructions. It sits between the core and the top-level memories and register file, and is driven by a debug or host command port.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command request.
- `cmd_op`, in, 2: command code. `2'b01` RUN, `2'b10` HALT, `2'b11` STEP, `2'b00` NOP.
- `cmd_ready`, out, 1: command accepted when `cmd_valid && cmd_ready` at an edge.
- `pc`, out, 32: current PC, driven to the core.
- `pc_new`, in, 32: next PC from the core.
- `instr`, in, 32: instruction at `pc` (instruction memory read data).
- `cpu_register_we3`, in, 1: core's register-file write enable.
- `cpu_data_memory_we`, in, 1: core's data-memory write enable.
- `register_we3`, out, 1: gated enable to the register file.
- `data_memory_we`, out, 1: gated enable to the data memory.
- `bp_valid`, in, 1: breakpoint armed.
- `bp_addr`, in, 32: breakpoint PC.
- `halted`, out, 1: high while in HALT.
- `halt_cause`, out, 2: reason for the last halt. 0 reset, 1 command/step, 2 ebreak, 3 breakpoint.
- `retired`, out, 32: retired-instruction counter.

## Operation
- States: HALT, RUN, STEP.
- **Commit cycle:** the cycle in RUN or STEP where no halt event fires. In that cycle:
  - `register_we3` follows `cpu_register_we3` and `data_memory_we` follows `cpu_data_memory_we`.
  - At the edge: `pc <= pc_new` and `retired <= retired + 1`.
  - `retired` wraps from `32'hFFFF_FFFF` to 0.
- **Non-commit cycles:** both gated write enables are 0, and `pc` and `retired` hold.
- **Halt events**, evaluated in RUN/STEP in priority order. Each suppresses the commit and sends the FSM to HALT, setting `halt_cause`:
  - `instr == 32'h0010_0073` (ebreak): cause 2. The PC stays on the ebreak.
  - Breakpoint: `bp_valid && pc == bp_addr && !skip_bp`: cause 3.
  - Accepted HALT command: cause 1.
- `skip_bp` is set on leaving HALT and cleared after the first commit, so resuming from a breakpoint PC executes that instruction.
- **HALT:**
  - RUN goes to RUN and STEP goes to STEP.
  - HALT and NOP are accepted with no effect.
  - An ebreak at the current `pc` is re-evaluated only after leaving HALT, so RUN on an ebreak halts again without committing. The host must move past it externally or via reset.
- **RUN:** only HALT has effect. RUN, STEP and NOP are accepted and ignored.
- **STEP:** exactly one commit, then HALT with cause 1. A halt event in that cycle wins and sets its own cause. `cmd_ready` is 0 in STEP.
- `cmd_ready` is 1 in HALT and RUN.

## Timing
- **Reset values** (applied at the edge with `reset` high, overriding everything including commands):
  - `pc = RESET_PC`, state HALT, `halted = 1`, `halt_cause = 0`, `retired = 0`, `skip_bp = 0`.
  - `register_we3 = 0` and `data_memory_we = 0` combinationally while in HALT.
- Reset asserted mid-RUN: the instruction in that cycle does not commit (enables forced 0 during reset).
- Write-enable gating is combinational, within the same cycle as the core's decode.
- Command accepted at edge n: the new state is visible at cycle n+1.
  - STEP: commit at edge n+1, `halted = 1` from cycle n+2.
- `halted` and `halt_cause` are registered. They update on the edge the FSM enters HALT.
- HALT command accepted in RUN at edge n: the instruction presented in cycle n does not commit.
- Simultaneous ebreak and HALT command: cause 2.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined:
  - Breakpoint compare and `skip_bp` logic are present.
  - Cause 3 is reachable.
- Undefined:
  - `bp_valid` and `bp_addr` ports remain but are ignored.
  - No compare logic; cause 3 is never produced.

## Test plan
- **Reset, then RUN** on a program of `addi x1,x0,5`; `addi x1,x1,1`; ebreak:
  - `retired = 2`, `x1 = 6`.
  - `halted = 1`, `halt_cause = 2`, `pc = 8`.
- **STEP from HALT** at `pc = 0`:
  - Exactly one commit; `pc = 4`, `retired = 1`, `halt_cause = 1`.
  - `cmd_ready = 0` for one cycle.
- **Breakpoint** (macro defined) with `bp_addr = 8`, RUN:
  - Halts with `pc = 8`, cause 3, and no write at 8.
  - A second RUN executes the instruction at 8 before any further breakpoint check.
- **HALT during a store loop:**
  - `data_memory_we` is 0 in the halt cycle and after it.
  - `retired` is frozen at its value before the halt cycle.
- **Reset asserted mid-RUN:**
  - Next cycle `pc = RESET_PC`, `retired = 0`, `halted = 1`, cause 0.
  - No write enable in the reset cycle.
- **Counter wrap:** force `retired = 32'hFFFF_FFFF`, commit one instruction → `retired = 0`.
